// File: rtl/freq_scheduler_if.sv
// Key-event inputs and frequency-request outputs between the keyboard decoder,
// the scheduler and the physics block.
interface freq_scheduler_if;
    logic       key_valid;
    logic [4:0] key_id;
    logic       key_down;
    logic [4:0] freq_id1;
    logic [4:0] freq_id2;
    logic       new_f;
    logic       busy;
    logic [7:0] reject_count;

    modport master (
        output key_valid, key_id, key_down,
        input  freq_id1, freq_id2, new_f, busy, reject_count
    );

    modport slave (
        input  key_valid, key_id, key_down,
        output freq_id1, freq_id2, new_f, busy, reject_count
    );
endinterface

// File: rtl/freq_scheduler.sv
// Tracks up to two held keys and issues coalesced frequency updates to physics,
// spaced by a programmable number of frames so bank swap and blend can finish.
module freq_scheduler #(
    parameter int unsigned HOLDOFF_FRAMES = 4,
    parameter int unsigned MAX_ID         = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vsync,
    freq_scheduler_if.slave   bus
);
    localparam int unsigned ID_W   = 5;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ID_W-1:0]   EMPTY    = ID_W'(31);
    localparam logic [ID_W-1:0]   MAX_ID_L = ID_W'(MAX_ID);
    localparam logic [HOLD_W-1:0] HOLD_L   = HOLD_W'(HOLDOFF_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [ID_W-1:0]     slot_a_q, slot_a_n;
    logic [ID_W-1:0]     slot_b_q, slot_b_n;
    logic                dirty_q, dirty_n;
    logic [HOLD_W-1:0]   hold_q, hold_n;
    logic [ID_W-1:0]     id1_q, id1_n;
    logic [ID_W-1:0]     id2_q, id2_n;
    logic                new_f_q, new_f_n;
    logic                busy_q, busy_n;
    logic [CNT_W-1:0]    rej_q, rej_n;
    logic                sync1_q, sync2_q, prev_q;
    logic                frame_tick;
    logic                slot_chg;
    logic                in_range;

    // vsync crosses into the pixel domain; a falling edge marks a frame
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= vsync;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign frame_tick = prev_q & ~sync2_q;

    // Held-key slot update: A is the older key, B the newer
    always_comb begin
        slot_a_n = slot_a_q;
        slot_b_n = slot_b_q;
        slot_chg = 1'b0;
        rej_n    = rej_q;
        in_range = (bus.key_id <= MAX_ID_L);
        if (bus.key_valid) begin
            if (bus.key_down) begin
                if (!in_range) begin
                    if (rej_q != CNT_MAX) begin
                        rej_n = rej_q + CNT_W'(1);
                    end
                end else if (bus.key_id != slot_a_q && bus.key_id != slot_b_q) begin
                    slot_chg = 1'b1;
                    if (slot_a_q == EMPTY) begin
                        slot_a_n = bus.key_id;
                    end else if (slot_b_q == EMPTY) begin
                        slot_b_n = bus.key_id;
                    end else begin
                        slot_a_n = slot_b_q;
                        slot_b_n = bus.key_id;
                    end
                end
            end else if (in_range) begin
                if (bus.key_id == slot_a_q) begin
                    slot_a_n = slot_b_q;
                    slot_b_n = EMPTY;
                    slot_chg = 1'b1;
                end else if (bus.key_id == slot_b_q) begin
                    slot_b_n = EMPTY;
                    slot_chg = 1'b1;
                end
            end
        end
    end

    // Issue sequencing; a key event accepted during ISSUE keeps dirty set
    always_comb begin
        state_n = state_q;
        dirty_n = dirty_q | slot_chg;
        hold_n  = hold_q;
        id1_n   = id1_q;
        id2_n   = id2_q;
        new_f_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (dirty_q) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                id1_n   = slot_a_q;
                id2_n   = slot_b_q;
                new_f_n = 1'b1;
                dirty_n = slot_chg;
                hold_n  = HOLD_L;
                state_n = (HOLD_L == '0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: begin
                if (frame_tick) begin
                    hold_n = hold_q - HOLD_W'(1);
                    if (hold_q <= HOLD_W'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            slot_a_q <= EMPTY;
            slot_b_q <= EMPTY;
            dirty_q  <= 1'b0;
            hold_q   <= '0;
            id1_q    <= EMPTY;
            id2_q    <= EMPTY;
            new_f_q  <= 1'b0;
            busy_q   <= 1'b0;
            rej_q    <= '0;
        end else begin
            state_q  <= state_n;
            slot_a_q <= slot_a_n;
            slot_b_q <= slot_b_n;
            dirty_q  <= dirty_n;
            hold_q   <= hold_n;
            id1_q    <= id1_n;
            id2_q    <= id2_n;
            new_f_q  <= new_f_n;
            busy_q   <= busy_n;
            rej_q    <= rej_n;
        end
    end

    assign bus.freq_id1     = id1_q;
    assign bus.freq_id2     = id2_q;
    assign bus.new_f        = new_f_q;
    assign bus.busy         = busy_q;
    assign bus.reject_count = rej_q;

endmodule

// File: tb/tb_freq_scheduler.sv
// Directed bench for freq_scheduler: latency, coalescing, holdoff, rejection
// and reset recovery, with a monitor counting pulses and illegal output changes.
module tb_freq_scheduler;
    logic clock;
    logic reset;
    logic vsync;

    freq_scheduler_if bus();

    freq_scheduler #(.HOLDOFF_FRAMES(4), .MAX_ID(24)) dut (
        .clock (clock),
        .reset (reset),
        .vsync (vsync),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int bad_change = 0;
    int cap1 = 31;
    int cap2 = 31;
    int prev1 = 31;
    int prev2 = 31;
    logic rst_at_edge = 1'b1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) rst_at_edge <= reset;

    // Pulse capture and detection of id changes without new_f
    always @(negedge clock) begin
        if (bus.new_f) begin
            pulse_cnt++;
            cap1 = int'(bus.freq_id1);
            cap2 = int'(bus.freq_id2);
        end
        if (!rst_at_edge && !bus.new_f &&
            (int'(bus.freq_id1) != prev1 || int'(bus.freq_id2) != prev2))
            bad_change++;
        prev1 = int'(bus.freq_id1);
        prev2 = int'(bus.freq_id2);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic key(input logic down, input int id);
        bus.key_valid = 1'b1;
        bus.key_down  = down;
        bus.key_id    = 5'(id);
        @(negedge clock);
        bus.key_valid = 1'b0;
    endtask

    task automatic frame();
        vsync = 1'b0;
        repeat (3) @(negedge clock);
        vsync = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic expect_pulse(input string tag, input int e1, input int e2);
        @(negedge clock);
        check({tag, "_early"}, int'(bus.new_f), 0);
        @(negedge clock);
        check({tag, "_new_f"}, int'(bus.new_f), 1);
        check({tag, "_id1"}, int'(bus.freq_id1), e1);
        check({tag, "_id2"}, int'(bus.freq_id2), e2);
    endtask

    task automatic holdoff_out();
        repeat (4) frame();
    endtask

    int p0;

    initial begin
        reset = 1'b1;
        vsync = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_down  = 1'b0;
        bus.key_id    = 5'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_id1", int'(bus.freq_id1), 31);
        check("rst_id2", int'(bus.freq_id2), 31);
        check("rst_new_f", int'(bus.new_f), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_rej", int'(bus.reject_count), 0);
        repeat (4) @(negedge clock);
        check("rst_no_pulse", pulse_cnt, 0);

        // press 5: two-cycle latency, one-cycle pulse, busy for four ticks
        key(1'b1, 5);
        expect_pulse("p5", 5, 31);
        check("p5_busy", int'(bus.busy), 1);
        @(negedge clock);
        check("p5_one_cycle", int'(bus.new_f), 0);
        repeat (3) frame();
        check("p5_busy_3", int'(bus.busy), 1);
        frame();
        check("p5_busy_4", int'(bus.busy), 0);
        check("p5_count", pulse_cnt, 1);

        key(1'b0, 5);
        expect_pulse("r5", 31, 31);
        holdoff_out();

        // press 3 then 7 on consecutive cycles coalesce into one issue
        bus.key_valid = 1'b1; bus.key_down = 1'b1; bus.key_id = 5'd3;
        @(negedge clock);
        bus.key_id = 5'd7;
        @(negedge clock);
        bus.key_valid = 1'b0;
        check("b37_early", int'(bus.new_f), 0);
        @(negedge clock);
        check("b37_new_f", int'(bus.new_f), 1);
        check("b37_id1", int'(bus.freq_id1), 3);
        check("b37_id2", int'(bus.freq_id2), 7);
        holdoff_out();
        check("b37_count", pulse_cnt, 3);

        // eviction of the oldest key, then release of the older slot
        key(1'b1, 10);
        expect_pulse("p10", 7, 10);
        holdoff_out();
        key(1'b0, 7);
        expect_pulse("r7", 10, 31);
        @(negedge clock);
        p0 = pulse_cnt;

        // churn during holdoff coalesces into one late issue
        repeat (3) begin
            key(1'b1, 12);
            key(1'b0, 12);
        end
        repeat (3) frame();
        check("churn_held", pulse_cnt, p0);
        check("churn_busy", int'(bus.busy), 1);
        frame();
        repeat (2) @(negedge clock);
        check("churn_count", pulse_cnt, p0 + 1);
        check("churn_id1", cap1, 10);
        check("churn_id2", cap2, 31);
        holdoff_out();
        check("churn_idle", int'(bus.busy), 0);

        // ignored releases and rejected presses
        p0 = pulse_cnt;
        key(1'b0, 20);
        key(1'b0, 30);
        check("rel_hi_rej", int'(bus.reject_count), 0);
        key(1'b1, 25);
        check("rej_25", int'(bus.reject_count), 1);
        key(1'b1, 31);
        repeat (4) @(negedge clock);
        check("rej_31", int'(bus.reject_count), 2);
        check("rej_no_pulse", pulse_cnt, p0);
        check("rej_busy", int'(bus.busy), 0);
        repeat (298) key(1'b1, 31);
        check("rej_sat", int'(bus.reject_count), 255);
        key(1'b1, 26);
        check("rej_sat_hold", int'(bus.reject_count), 255);

        // reset mid-holdoff with a pending change discards it
        key(1'b1, 3);
        expect_pulse("p3", 10, 3);
        key(1'b1, 4);
        frame();
        check("pre_rst_busy", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_id1", int'(bus.freq_id1), 31);
        check("mid_rst_id2", int'(bus.freq_id2), 31);
        check("mid_rst_new_f", int'(bus.new_f), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_rej", int'(bus.reject_count), 0);
        @(negedge clock);
        p0 = pulse_cnt;
        repeat (10) @(negedge clock);
        check("mid_rst_discard", pulse_cnt, p0);
        key(1'b1, 8);
        expect_pulse("p8", 8, 31);

        repeat (2) @(negedge clock);
        check("no_silent_change", bad_change, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
